drop_scheduler: RTL and testbench

- Consumer of the LFSR drop triggers (easy_t / normal_t / extreme_t).
- On each game tick, selects the trigger for the current difficulty and enforces a minimum spawn spacing (cooldown).
- Picks a target column and queues spawn requests in a small FIFO.
- The FIFO feeds the object/render logic over a valid/ready handshake.

---
 rtl/drop_pkg.sv | 18 +
 rtl/drop_fifo.sv | 54 +++++
 rtl/drop_scheduler.sv | 130 +++++++++++++
 tb/tb_drop_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/drop_pkg.sv
// Shared encodings and defaults for the drop scheduler slice.
package drop_pkg;

   localparam int unsigned DEF_NUM_COLS = 8;
   localparam int unsigned DEF_COL_W    = 3;

   localparam logic [1:0] LVL_EASY    = 2'd0;
   localparam logic [1:0] LVL_NORMAL  = 2'd1;
   localparam logic [1:0] LVL_EXTREME = 2'd2;
   localparam logic [1:0] LVL_PAUSE   = 2'd3;

   typedef enum logic [1:0] {
      READY = 2'd0,
      COOL  = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/drop_fifo.sv
// Show-ahead FIFO for pending spawn columns; DEPTH must be a power of 2 and >= 2.
module drop_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 3,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout_c,
   output logic [AW:0]   count,
   output logic          full_c,
   output logic          empty_c,
   output logic          push_ok_c
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop_c;

   // Status decode; a push into a full FIFO is still taken when a pop frees the slot.
   always_comb begin
      full_c    = (count == (AW+1)'(DEPTH));
      empty_c   = (count == '0);
      do_pop_c  = pop & ~empty_c;
      push_ok_c = push & (~full_c | do_pop_c);
      dout_c    = mem[rd_ptr];
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok_c) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok_c, do_pop_c})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/drop_scheduler.sv
// Turns difficulty-selected LFSR triggers into spaced spawn requests queued for the renderer.
module drop_scheduler
   import drop_pkg::*;
#(
   parameter int unsigned NUM_COLS   = DEF_NUM_COLS,
   parameter int unsigned COL_W      = DEF_COL_W,
   parameter int unsigned COOLDOWN   = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [1:0]       level,
   input  logic             easy_t,
   input  logic             normal_t,
   input  logic             extreme_t,
   input  logic [COL_W-1:0] col_seed,
   output logic             spawn_valid,
   output logic [COL_W-1:0] spawn_col,
   input  logic             spawn_ready,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   localparam int unsigned SEED_W = COL_W + 1;
   localparam int unsigned CD_W   = 4;

   state_t           state;
   logic [CD_W-1:0]  cooldown;
   logic [COL_W-1:0] last_col;

   logic             trig_c;
   logic [SEED_W-1:0] seed_ext_c;
   logic [COL_W-1:0] base_c;
   logic [COL_W-1:0] col_c;
   logic             push_req_c;
   logic             pop_c;
   logic             push_ok_c;
   logic             full_c;
   logic             empty_c;
   logic [COL_W-1:0] head_c;

   // Trigger for the current difficulty; pause never triggers.
   always_comb begin
      trig_c = 1'b0;
      case (level)
         LVL_EASY:    trig_c = easy_t;
         LVL_NORMAL:  trig_c = normal_t;
         LVL_EXTREME: trig_c = extreme_t;
         default:     trig_c = 1'b0;
      endcase
   end

   // Fold the seed into range, then step past the previous column to avoid repeats.
   always_comb begin
      seed_ext_c = {1'b0, col_seed};
      if (seed_ext_c < SEED_W'(NUM_COLS)) base_c = col_seed;
      else                                 base_c = COL_W'(seed_ext_c - SEED_W'(NUM_COLS));
      col_c = base_c;
      if (base_c == last_col)
         col_c = (base_c == COL_W'(NUM_COLS - 1)) ? '0 : base_c + COL_W'(1);
   end

   // Push requests only come from READY on a ticked cycle; pops follow the handshake.
   always_comb begin
      push_req_c = tick & (state == READY) & trig_c;
      pop_c      = spawn_valid & spawn_ready;
   end

   drop_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (COL_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_req_c),
      .din       (col_c),
      .pop       (pop_c),
      .dout_c    (head_c),
      .count     (pending),
      .full_c    (full_c),
      .empty_c   (empty_c),
      .push_ok_c (push_ok_c)
   );

   // Head of queue is presented directly from the FIFO registers.
   always_comb begin
      spawn_valid = ~empty_c;
      spawn_col   = head_c;
   end

   // Spacing FSM plus the lost-spawn pulse; nothing moves except on ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= READY;
         cooldown <= '0;
         last_col <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push_req_c & ~push_ok_c;
         if (tick) begin
            case (state)
               READY: begin
                  if (level == LVL_PAUSE) begin
                     state <= HOLD;
                  end else if (push_ok_c) begin
                     cooldown <= CD_W'(COOLDOWN);
                     last_col <= col_c;
                     state    <= COOL;
                  end
               end
               COOL: begin
                  if (level == LVL_PAUSE) begin
                     state <= HOLD;
                  end else begin
                     cooldown <= cooldown - CD_W'(1);
                     if (cooldown <= CD_W'(1)) state <= READY;
                  end
               end
               HOLD: begin
                  if (level != LVL_PAUSE) state <= (cooldown != '0) ? COOL : READY;
               end
               default: state <= READY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed scoreboard bench: stimulus queues expected columns, monitors check each pop.
module tb_drop_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Instance A: 8 columns, cooldown 4
   logic       tick_a, easy_a, normal_a, extreme_a, ready_a, valid_a, ovf_a;
   logic [1:0] level_a;
   logic [2:0] seed_a, col_a, pending_a;

   // Instance B: 6 columns, cooldown 1
   logic       tick_b, easy_b, normal_b, extreme_b, ready_b, valid_b, ovf_b;
   logic [1:0] level_b;
   logic [2:0] seed_b, col_b, pending_b;

   int n_err = 0;
   int n_chk = 0;
   int exp_a[$];
   int exp_b[$];

   drop_scheduler #(.NUM_COLS(8), .COL_W(3), .COOLDOWN(4), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .tick(tick_a), .level(level_a),
      .easy_t(easy_a), .normal_t(normal_a), .extreme_t(extreme_a), .col_seed(seed_a),
      .spawn_valid(valid_a), .spawn_col(col_a), .spawn_ready(ready_a),
      .pending(pending_a), .overflow(ovf_a)
   );

   drop_scheduler #(.NUM_COLS(6), .COL_W(3), .COOLDOWN(1), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .tick(tick_b), .level(level_b),
      .easy_t(easy_b), .normal_t(normal_b), .extreme_t(extreme_b), .col_seed(seed_b),
      .spawn_valid(valid_b), .spawn_col(col_b), .spawn_ready(ready_b),
      .pending(pending_b), .overflow(ovf_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Ticks with whatever triggers are currently applied to A.
   task automatic a_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_a = 1'b1;
         step();
      end
      tick_a = 1'b0;
   endtask

   // Monitor A: every handshake must match the oldest expected column.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_a === 1'b1 && ready_a === 1'b1) begin
         if (exp_a.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL a_unexpected_pop: actual col=%0d required no entry", col_a);
         end else begin
            check("a_pop_col", 32'(col_a), exp_a.pop_front());
         end
      end
   end

   // Monitor B: same for the second instance.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_b === 1'b1 && ready_b === 1'b1) begin
         if (exp_b.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL b_unexpected_pop: actual col=%0d required no entry", col_b);
         end else begin
            check("b_pop_col", 32'(col_b), exp_b.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      tick_a = 0; easy_a = 0; normal_a = 0; extreme_a = 0; ready_a = 0; level_a = 2'd0; seed_a = 3'd0;
      tick_b = 0; easy_b = 0; normal_b = 0; extreme_b = 0; ready_b = 0; level_b = 2'd0; seed_b = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_valid", 32'(valid_a), 0);
      check("rst_a_pending", 32'(pending_a), 0);
      check("rst_a_col", 32'(col_a), 0);
      check("rst_a_ovf", 32'(ovf_a), 0);
      check("rst_b_valid", 32'(valid_b), 0);
      check("rst_b_pending", 32'(pending_b), 0);
      rst_n = 1'b1;
      step();

      // ---- B: seed fold, saturation, overflow, push+pop when full ----
      level_b = 2'd1; normal_b = 1'b1; ready_b = 1'b0;
      tick_b = 1'b1; seed_b = 3'd7;
      check("b_valid_before", 32'(valid_b), 0);
      exp_b.push_back(1);
      step();
      check("b_fold_col", 32'(col_b), 1);
      check("b_pending1", 32'(pending_b), 1);
      step();                                   // cooldown tick
      check("b_cool_pending", 32'(pending_b), 1);
      seed_b = 3'd7; exp_b.push_back(2); step();  // repeat avoidance 1 -> 2
      check("b_pending2", 32'(pending_b), 2);
      step();
      seed_b = 3'd0; exp_b.push_back(0); step();
      check("b_pending3", 32'(pending_b), 3);
      step();
      seed_b = 3'd5; exp_b.push_back(5); step();
      check("b_pending4", 32'(pending_b), 4);
      step();
      seed_b = 3'd3; step();                     // full, no pop: dropped
      check("b_ovf_pulse", 32'(ovf_b), 1);
      check("b_ovf_pending", 32'(pending_b), 4);
      tick_b = 1'b0; step();
      check("b_ovf_one_cycle", 32'(ovf_b), 0);
      tick_b = 1'b1; ready_b = 1'b1; seed_b = 3'd3;
      exp_b.push_back(3);                        // still READY, last_col still 5
      step();
      check("b_pushpop_ovf", 32'(ovf_b), 0);
      check("b_pushpop_pending", 32'(pending_b), 4);
      tick_b = 1'b0;
      repeat (5) step();
      check("b_drained", 32'(pending_b), 0);
      ready_b = 1'b0;

      // ---- A: first spawn latency and cooldown spacing ----
      level_a = 2'd1; normal_a = 1'b1; seed_a = 3'd5; tick_a = 1'b1;
      check("a_valid_before", 32'(valid_a), 0);
      exp_a.push_back(5);
      step();
      check("a_first_valid", 32'(valid_a), 1);
      check("a_first_col", 32'(col_a), 5);
      check("a_first_pending", 32'(pending_a), 1);
      for (int i = 0; i < 4; i++) begin
         tick_a = 1'b1; step();
         check("a_cool_nopush", 32'(pending_a), 1);
      end
      exp_a.push_back(6);                        // 5th tick, seed 5 repeats last col
      tick_a = 1'b1; step();
      check("a_second_push", 32'(pending_a), 2);
      tick_a = 1'b0;
      ready_a = 1'b1; normal_a = 1'b0;
      a_ticks(4);
      check("a_drain", 32'(pending_a), 0);

      // ---- A: wrap 7 -> 0 ----
      normal_a = 1'b1; seed_a = 3'd7; exp_a.push_back(7);
      a_ticks(1);
      check("a_push7", 32'(pending_a), 1);
      normal_a = 1'b0; a_ticks(4);
      normal_a = 1'b1; seed_a = 3'd7; exp_a.push_back(0);
      a_ticks(1);
      check("a_wrap_col", 32'(col_a), 0);
      normal_a = 1'b0; a_ticks(4);

      // ---- A: level selects the trigger ----
      level_a = 2'd0; easy_a = 1'b0; normal_a = 1'b1; extreme_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a_ticks(1);
         check("a_easy_gate", 32'(pending_a), 0);
      end
      level_a = 2'd2; ready_a = 1'b0; seed_a = 3'd3; exp_a.push_back(3);
      a_ticks(1);
      check("a_extreme_push", 32'(pending_a), 1);
      check("a_extreme_col", 32'(col_a), 3);

      // ---- A: pause with cooldown 2 ----
      a_ticks(2);
      check("a_cool_hold_pending", 32'(pending_a), 1);
      level_a = 2'd3; ready_a = 1'b1;
      a_ticks(10);
      check("a_hold_drain_pending", 32'(pending_a), 0);
      check("a_hold_drain_valid", 32'(valid_a), 0);
      ready_a = 1'b0; level_a = 2'd2; seed_a = 3'd2;
      a_ticks(1);
      check("a_exit_nopush", 32'(pending_a), 0);
      a_ticks(1);
      check("a_resume_cd1", 32'(pending_a), 0);
      a_ticks(1);
      check("a_resume_cd0", 32'(pending_a), 0);
      exp_a.push_back(2);
      a_ticks(1);
      check("a_resume_push", 32'(pending_a), 1);
      check("a_resume_col", 32'(col_a), 2);

      // ---- A: fill to 3 then async reset ----
      a_ticks(4);
      seed_a = 3'd4; exp_a.push_back(4); a_ticks(1);
      check("a_fill2", 32'(pending_a), 2);
      a_ticks(4);
      seed_a = 3'd4; exp_a.push_back(5); a_ticks(1);
      check("a_fill3", 32'(pending_a), 3);
      check("a_fill3_valid", 32'(valid_a), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("a_async_valid", 32'(valid_a), 0);
      check("a_async_pending", 32'(pending_a), 0);
      check("a_async_col", 32'(col_a), 0);
      exp_a.delete();
      exp_b.delete();
      #2;
      rst_n = 1'b1;
      step();
      seed_a = 3'd5; exp_a.push_back(5);
      a_ticks(1);
      check("a_post_rst_push", 32'(pending_a), 1);
      check("a_post_rst_col", 32'(col_a), 5);
      ready_a = 1'b1;
      repeat (3) step();
      check("a_final_drain", 32'(pending_a), 0);

      check("a_queue_empty", 32'(exp_a.size()), 0);
      check("b_queue_empty", 32'(exp_b.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
